// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO bank: register offsets, register index
// type and the address decoder used by the bus front end.
package gpio_pkg;

  localparam logic [4:0] GPIO_OFS_DOUT  = 5'h00;
  localparam logic [4:0] GPIO_OFS_DIR   = 5'h04;
  localparam logic [4:0] GPIO_OFS_DIN   = 5'h08;
  localparam logic [4:0] GPIO_OFS_IEN   = 5'h0C;
  localparam logic [4:0] GPIO_OFS_ISTAT = 5'h10;
  localparam logic [4:0] GPIO_OFS_IPOL  = 5'h14;

  typedef enum logic [2:0] {
    REG_DOUT,
    REG_DIR,
    REG_DIN,
    REG_IEN,
    REG_ISTAT,
    REG_IPOL,
    REG_NONE
  } gpio_reg_e;

  // Map a byte address to a register; anything outside the 32-byte window,
  // not word aligned, or on an unmapped offset becomes REG_NONE.
  function automatic gpio_reg_e gpio_decode(input logic [31:0] addr,
                                            input logic [26:0] base_hi);
    gpio_reg_e sel;
    sel = REG_NONE;
    if (addr[31:5] == base_hi && addr[1:0] == 2'b00) begin
      case (addr[4:0])
        GPIO_OFS_DOUT:  sel = REG_DOUT;
        GPIO_OFS_DIR:   sel = REG_DIR;
        GPIO_OFS_DIN:   sel = REG_DIN;
        GPIO_OFS_IEN:   sel = REG_IEN;
        GPIO_OFS_ISTAT: sel = REG_ISTAT;
        GPIO_OFS_IPOL:  sel = REG_IPOL;
        default:        sel = REG_NONE;
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Per-pin two-flop synchroniser followed by a history flop; the synchronised
// value and its previous value give single-cycle rise/fall pulses.
module gpio_sync_edge #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] pin_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);

  logic [WIDTH-1:0] s1_q, s2_q, prev_q;

  // Metastability chain plus one cycle of history for edge detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q   <= '0;
      s2_q   <= '0;
      prev_q <= '0;
    end else begin
      s1_q   <= pin_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign sync_o = s2_q;
  assign rise_o = s2_q & ~prev_q;
  assign fall_o = ~s2_q & prev_q;

endmodule

// File: rtl/gpio_bank.sv
// Memory-mapped GPIO bank: output latch, direction, synchronised inputs and
// sticky edge interrupts. Defining GPIO_BANK_FALLING_EDGE_EN adds the
// per-pin IRQ_POL register (falling-edge select); otherwise IRQ_POL reads 0.
// Bus: a write lands on the edge where we is high; a read sampled on the
// edge where re is high returns rdata with a one-cycle rvalid pulse on the
// following cycle, using pre-write register contents.
module gpio_bank #(
  parameter int               WIDTH     = 32,
  parameter logic [31:0]      BASE_ADDR = 32'h0000_AB00,
  parameter logic [WIDTH-1:0] OUT_RESET = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  input  logic             we,
  input  logic             re,
  output logic [31:0]      rdata,
  output logic             rvalid,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);
  import gpio_pkg::*;

  gpio_reg_e        sel;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] dout_q, dout_d, dir_q, dir_d, ien_q, ien_d;
  logic [WIDTH-1:0] istat_q, istat_d;
  logic [WIDTH-1:0] din, rise, fall, edge_evt, ipol;
  logic [31:0]      rdata_q, rdata_d;
  logic             rvalid_q, irq_q, irq_d;

  assign sel = gpio_decode(addr, BASE_ADDR[31:5]);
  assign wd  = wdata[WIDTH-1:0];

  function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
    logic [31:0] r;
    r = '0;
    r[WIDTH-1:0] = v;
    return r;
  endfunction

  gpio_sync_edge #(.WIDTH(WIDTH)) u_sync_edge (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .pin_i  (gpio_in),
    .sync_o (din),
    .rise_o (rise),
    .fall_o (fall)
  );

`ifdef GPIO_BANK_FALLING_EDGE_EN
  logic [WIDTH-1:0] ipol_q, ipol_d;

  // Polarity register update.
  always_comb begin
    ipol_d = ipol_q;
    if (we && sel == REG_IPOL) ipol_d = wd;
  end

  // Polarity register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ipol_q <= '0;
    else        ipol_q <= ipol_d;
  end

  assign ipol     = ipol_q;
  assign edge_evt = (rise & ~ipol_q) | (fall & ipol_q);
`else
  logic unused_fall;
  assign unused_fall = ^fall;
  assign ipol        = '0;
  assign edge_evt    = rise;
`endif

  // Register writes; a status edge overrides a same-cycle W1C.
  always_comb begin
    dout_d  = dout_q;
    dir_d   = dir_q;
    ien_d   = ien_q;
    istat_d = istat_q;
    if (we) begin
      case (sel)
        REG_DOUT:  dout_d  = wd;
        REG_DIR:   dir_d   = wd;
        REG_IEN:   ien_d   = wd;
        REG_ISTAT: istat_d = istat_q & ~wd;
        default:   ;
      endcase
    end
    istat_d = istat_d | edge_evt;
  end

  // Read mux over current (pre-write) contents; rdata holds between reads.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      case (sel)
        REG_DOUT:  rdata_d = zext(dout_q);
        REG_DIR:   rdata_d = zext(dir_q);
        REG_DIN:   rdata_d = zext(din);
        REG_IEN:   rdata_d = zext(ien_q);
        REG_ISTAT: rdata_d = zext(istat_q);
        REG_IPOL:  rdata_d = zext(ipol);
        default:   rdata_d = '0;
      endcase
    end
  end

  // Interrupt follows the status/enable registers by one cycle.
  always_comb begin
    irq_d = |(istat_q & ien_q);
  end

  // Register state and bus response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q   <= OUT_RESET;
      dir_q    <= '0;
      ien_q    <= '0;
      istat_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      dout_q   <= dout_d;
      dir_q    <= dir_d;
      ien_q    <= ien_d;
      istat_q  <= istat_d;
      rdata_q  <= rdata_d;
      rvalid_q <= re;
      irq_q    <= irq_d;
    end
  end

  assign rdata    = rdata_q;
  assign rvalid   = rvalid_q;
  assign gpio_out = dout_q;
  assign gpio_oe  = dir_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_gpio_bank.sv
// Bench for gpio_bank: directed scenarios followed by random bus/pin traffic,
// checked against a register-level reference model and a read scoreboard.
module tb_gpio_bank;

  localparam int          W       = 32;
  localparam logic [31:0] BASE    = 32'h0000_AB00;
  localparam logic [31:0] OUT_RST = 32'h0000_5A00;

  // ---------------- clock / reset ----------------
  logic clk, rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] addr, wdata, rdata;
  logic        we, re, rvalid, irq;
  logic [W-1:0] pins, gpio_out, gpio_oe;

  gpio_bank #(.WIDTH(W), .BASE_ADDR(BASE), .OUT_RESET(OUT_RST)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .addr     (addr),
    .wdata    (wdata),
    .we       (we),
    .re       (re),
    .rdata    (rdata),
    .rvalid   (rvalid),
    .gpio_in  (pins),
    .gpio_out (gpio_out),
    .gpio_oe  (gpio_oe),
    .irq      (irq)
  );

  int checks = 0;
  int failures = 0;
  bit checking = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Registers as the programmer sees them, plus a delay line of pin values
  // sampled at each edge (h0 newest). A pin level becomes visible to software
  // two edges after it is sampled; an edge event compares it with the level
  // one edge older still.
  logic [31:0] m_dout, m_dir, m_ien, m_istat, m_ipol, h0, h1, h2, last_rd;
  logic        m_irq;
  logic [31:0] exp_q[$];

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (a[31:5] != BASE[31:5] || a[1:0] != 2'b00) return 32'h0;
    case (a[4:0])
      5'h00:   return m_dout;
      5'h04:   return m_dir;
      5'h08:   return h1;
      5'h0C:   return m_ien;
      5'h10:   return m_istat;
      5'h14:   return m_ipol;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [31:0] ev, nstat;
    logic        hit;
    if (!rst_n) begin
      m_dout = OUT_RST; m_dir = 0; m_ien = 0; m_istat = 0; m_ipol = 0;
      m_irq = 0; h0 = 0; h1 = 0; h2 = 0; last_rd = 0;
      exp_q.delete();
    end else begin
`ifdef GPIO_BANK_FALLING_EDGE_EN
      ev = (h1 & ~h2 & ~m_ipol) | (~h1 & h2 & m_ipol);
`else
      ev = h1 & ~h2;
`endif
      hit = (addr[31:5] == BASE[31:5]) && (addr[1:0] == 2'b00);
      if (re) exp_q.push_back(m_read(addr));
      m_irq = |(m_istat & m_ien);
      nstat = m_istat;
      if (we && hit) begin
        case (addr[4:0])
          5'h00: m_dout = wdata;
          5'h04: m_dir  = wdata;
          5'h0C: m_ien  = wdata;
          5'h10: nstat  = m_istat & ~wdata;
`ifdef GPIO_BANK_FALLING_EDGE_EN
          5'h14: m_ipol = wdata;
`endif
          default: ;
        endcase
      end
      m_istat = nstat | ev;
      h2 = h1; h1 = h0; h0 = pins;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [31:0] e;
    if (checking) begin
      check("rvalid", {31'b0, rvalid}, {31'b0, exp_q.size() != 0});
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (rvalid) check("rdata", rdata, e);
        last_rd = e;
      end else begin
        check("rdata_hold", rdata, last_rd);
      end
      check("gpio_out", gpio_out, m_dout);
      check("gpio_oe", gpio_oe, m_dir);
      check("irq", {31'b0, irq}, {31'b0, m_irq});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic op(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    we = w; re = r; addr = a; wdata = d;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) op(0, 0, 32'h0, 32'h0);
  endtask
  task automatic wr(input logic [4:0] ofs, input logic [31:0] d);
    op(1, 0, BASE + {27'b0, ofs}, d);
  endtask
  task automatic rd(input logic [31:0] a);
    op(0, 1, a, 32'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] ofs_tab [10];
    ofs_tab = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C, 32'h01, 32'h20};
    we = 0; re = 0; addr = 0; wdata = 0; pins = 0; rst_n = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    checking = 1;

    // reset readback of every offset
    for (int o = 0; o < 32; o += 4) rd(BASE + o);
    idle(1);

    // output latch and direction
    wr(5'h04, 32'h0000_00FF);
    wr(5'h00, 32'hA5A5_A5A5);
    rd(BASE); rd(BASE + 4); idle(1);

    // rising edge on bit 3 with IRQ_EN set, then W1C
    wr(5'h0C, 32'h8);
    idle(1); pins[3] = 1'b1;
    idle(4); rd(BASE + 32'h10);
    wr(5'h10, 32'h8); idle(2); rd(BASE + 32'h10);

    // edge arriving on the same edge as the W1C of that bit
    idle(1); pins[3] = 1'b0; idle(4);
    idle(1); pins[3] = 1'b1;
    idle(1);
    wr(5'h10, 32'h8);
    idle(2); rd(BASE + 32'h10);
    wr(5'h10, 32'hFFFF_FFFF); idle(2);

    // ignored addresses and simultaneous read/write
    op(1, 0, BASE + 32'h20, 32'hDEAD_BEEF);
    op(1, 0, BASE + 32'h01, 32'hDEAD_BEEF);
    op(1, 0, BASE + 32'h18, 32'hDEAD_BEEF);
    op(1, 0, BASE ^ 32'h0001_0000, 32'hDEAD_BEEF);
    rd(BASE + 32'h20); rd(BASE + 32'h01); rd(BASE + 32'h18); rd(BASE);
    op(1, 1, BASE, 32'h1234_5678); rd(BASE); idle(1);

    // polarity select (falling edge when the feature is built in)
    wr(5'h14, 32'h1); rd(BASE + 32'h14);
    idle(1); pins[0] = 1'b1; idle(4);
    wr(5'h10, 32'hFFFF_FFFF); idle(1);
    pins[0] = 1'b0; idle(4); rd(BASE + 32'h10);
    wr(5'h10, 32'hFFFF_FFFF); idle(1);
    pins[0] = 1'b1; idle(4); rd(BASE + 32'h10);
    wr(5'h14, 32'h0); idle(1);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      logic [31:0] a;
      logic        w, r;
      if ($urandom_range(0, 9) == 0) a = $urandom();
      else a = BASE + ofs_tab[$urandom_range(0, 9)];
      w = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 2) == 0);
      op(w, r, a, $urandom());
      if ($urandom_range(0, 3) == 0) pins = pins ^ (32'h1 << $urandom_range(0, 7));
    end

    // reset with a read in flight: the read is dropped
    @(negedge clk);
    we = 0; re = 1; addr = BASE + 32'h04; wdata = 0;
    #2 rst_n = 0;
    @(negedge clk);
    re = 0;
    #2 rst_n = 1;
    rd(BASE); rd(BASE + 32'h04); rd(BASE + 32'h10);
    idle(4);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    checking = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gpio_bank.md
Name: gpio_bank

Overview:
Memory-mapped, parametrised GPIO bank on the core's data-memory bus. It provides a registered output latch, a per-bit direction register, synchronised input sampling, and rising-edge interrupts with sticky status. It replaces the single-address combinational output decoder. It sits beside data memory, decoded by BASE_ADDR.

Parameters:
WIDTH, 32, number of GPIO pins (1..32); unused upper data bits read 0.
BASE_ADDR, 32'h0000_AB00, byte address of register 0; must be 32-byte aligned.
OUT_RESET, 0, reset value of DATA_OUT (WIDTH bits).

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
addr  input  32  byte address from core
wdata  input  32  write data
we  input  1  write strobe, single cycle
re  input  1  read strobe, single cycle
rdata  output  32  read data, registered
rvalid  output  1  high one cycle after an accepted read
gpio_in  input  WIDTH  external pins, asynchronous to clk
gpio_out  output  WIDTH  output latch value
gpio_oe  output  WIDTH  per-bit output enable (1 = drive)
irq  output  1  level interrupt to core

Behaviour:
- Register map (offset from BASE_ADDR):
  - 0x00 DATA_OUT, R/W
  - 0x04 DIR, R/W, 1 = output
  - 0x08 DATA_IN, RO, synchronised pins
  - 0x0C IRQ_EN, R/W
  - 0x10 IRQ_STAT, R/W1C
  - 0x14 IRQ_POL, see Optional Feature
- Decode: hit when addr[31:5] == BASE_ADDR[31:5] and addr[1:0] == 0. Misaligned addresses, out-of-range addresses and unmapped offsets are ignored on write. A read of any of these returns 0 with rvalid still asserted.
- Reset values: DATA_OUT = OUT_RESET, DIR = 0, IRQ_EN = 0, IRQ_STAT = 0, rdata = 0, rvalid = 0, sync flops = 0, irq = 0.
- Writes take effect on the clock edge where we is high. gpio_out/gpio_oe reflect the new value the next cycle.
- Reads: rdata/rvalid are valid the cycle after re (1-cycle latency). rdata holds its value until the next read; rvalid is a pulse.
- If we and re are asserted together on the same register, the read returns the pre-write value.
- Input path: 2-flop synchroniser per bit, then a 3rd flop holds the previous value. DATA_IN = 2nd flop. Latency from pin to DATA_IN is 2–3 cycles.
- Edge detect: rise[i] = sync[i] & ~prev[i]. When rise[i] is high, IRQ_STAT[i] is set, regardless of IRQ_EN.
- W1C: writing 1 to IRQ_STAT[i] clears it. If an edge arrives in the same cycle as the clear, the set wins and the bit stays 1.
- irq = |(IRQ_STAT & IRQ_EN), registered (1 cycle after the status update). Setting IRQ_EN on an already-pending bit raises irq the next cycle.
- Pins with DIR = 1 still sample and can still interrupt (loopback permitted).
- Reset mid-operation clears all state immediately. A read in flight is dropped (rvalid stays 0).

Optional Feature:
Macro GPIO_BANK_FALLING_EDGE_EN.
- Defined: IRQ_POL (0x14, R/W, reset 0) is implemented. Bit = 1 selects falling edge (~sync & prev) for that pin; bit = 0 selects rising edge.
- Undefined: IRQ_POL reads 0, writes are ignored, and all pins are rising-edge only.

Decomposition:
- Shared package gpio_pkg:
  - Offset constants GPIO_OFS_DOUT, GPIO_OFS_DIR, GPIO_OFS_DIN, GPIO_OFS_IEN, GPIO_OFS_ISTAT, GPIO_OFS_IPOL.
  - Register index typedef.
- One sub-module, gpio_sync_edge: WIDTH-wide 2-flop synchroniser, prev register, and rise/fall outputs. The top level instantiates it once.

Test Plan:
- Reset, then read all offsets -> DATA_OUT = OUT_RESET, others 0, irq = 0; rvalid a single pulse per read.
- Write DIR = 0x0000_00FF, then DATA_OUT = 0xA5A5_A5A5 -> next cycle gpio_oe = 0xFF, gpio_out = 0xA5A5_A5A5; readback matches.
- Drive gpio_in[3] 0→1 with IRQ_EN = 0x8 -> IRQ_STAT = 0x8 within 3 cycles, irq high 1 cycle later. W1C 0x8 -> irq low the cycle after.
- Edge on bit 3 coincides with the W1C of bit 3 -> IRQ_STAT[3] stays 1 and irq stays high.
- Write to BASE_ADDR + 0x20 and to BASE_ADDR + 0x01 -> no register changes; a read there returns 0 with rvalid = 1.
- With GPIO_BANK_FALLING_EDGE_EN defined: IRQ_POL = 0x1, gpio_in[0] 1→0 -> IRQ_STAT[0] set, and a 0→1 transition does not set it. Undefined: IRQ_POL reads 0.
